// File: rtl/ds_frame_sequencer_if.sv
// Sample stream into the sequencer and the strobe/code bundle it drives into the
// delta-sigma modulator.
interface ds_frame_sequencer_if #(
    parameter int BITS = 5
) ();
    logic            s_valid;
    logic [BITS-1:0] s_data;
    logic            s_ready;
    logic [BITS-1:0] ds_data;
    logic            ds_data_en;
    logic            ds_next;
    logic            frame_start;

    modport master (
        output s_valid, s_data,
        input  s_ready, ds_data, ds_data_en, ds_next, frame_start
    );
    modport slave (
        input  s_valid, s_data,
        output s_ready, ds_data, ds_data_en, ds_next, frame_start
    );
endinterface

// File: rtl/ds_frame_sequencer.sv
// Delta-sigma step sequencer: prescaled step strobe, frame grouping, and a one-entry
// code buffer whose contents are applied to the modulator only on frame boundaries.
module ds_frame_sequencer #(
    parameter int BITS    = 5,
    parameter int DIV_W   = 8,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DIV_W-1:0]   div,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               clr_underrun,
    ds_frame_sequencer_if.slave bus,
    output logic               underrun
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   pcnt, pcnt_d;
    logic [FRAME_W-1:0] fcnt, fcnt_d;
    logic [BITS-1:0]    buf_q, buf_d;
    logic [BITS-1:0]    ds_data_q, ds_data_d;
    logic               full, full_d;
    logic               underrun_q, underrun_d;
    logic               ds_next_q, ds_next_d;
    logic               ds_data_en_q, ds_data_en_d;
    logic               frame_start_q, frame_start_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // enable acts on the very edge that samples it, in both directions
    always_comb begin
        state_nxt = enable ? RUN : IDLE;
    end

    always_comb begin
        pcnt_d        = pcnt;
        fcnt_d        = fcnt;
        buf_d         = buf_q;
        full_d        = full;
        ds_data_d     = ds_data_q;
        underrun_d    = underrun_q;
        ds_next_d     = 1'b0;
        ds_data_en_d  = 1'b0;
        frame_start_d = 1'b0;

        if (bus.s_valid && !full) begin
            full_d = 1'b1;
            buf_d  = bus.s_data;
        end
        if (clr_underrun) underrun_d = 1'b0;

        if (state_nxt == IDLE) begin
            pcnt_d = div;
            fcnt_d = '0;
        end else if (pcnt != '0) begin
            pcnt_d = pcnt - DIV_W'(1);
        end else begin
            ds_next_d = 1'b1;
            pcnt_d    = div;
            // the first step out of IDLE always opens a frame
            if (state == IDLE || fcnt == '0) begin
                frame_start_d = 1'b1;
                fcnt_d        = frame_len;
                if (full) begin
                    ds_data_d    = buf_q;
                    ds_data_en_d = 1'b1;
                    full_d       = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                fcnt_d = fcnt - FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt          <= '0;
            fcnt          <= '0;
            buf_q         <= '0;
            full          <= 1'b0;
            ds_data_q     <= '0;
            underrun_q    <= 1'b0;
            ds_next_q     <= 1'b0;
            ds_data_en_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pcnt          <= pcnt_d;
            fcnt          <= fcnt_d;
            buf_q         <= buf_d;
            full          <= full_d;
            ds_data_q     <= ds_data_d;
            underrun_q    <= underrun_d;
            ds_next_q     <= ds_next_d;
            ds_data_en_q  <= ds_data_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.s_ready     = !full;
    assign bus.ds_data     = ds_data_q;
    assign bus.ds_data_en  = ds_data_en_q;
    assign bus.ds_next     = ds_next_q;
    assign bus.frame_start = frame_start_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_ds_frame_sequencer.sv
// Bench for ds_frame_sequencer: table of pacing/framing configs plus directed
// sequences; applied codes are checked through a scoreboard queue.
module tb_ds_frame_sequencer;
    localparam int BITS = 5, DIV_W = 8, FRAME_W = 8;

    logic               clk = 1'b0;
    logic               rst, enable, clr_underrun, underrun;
    logic [DIV_W-1:0]   div;
    logic [FRAME_W-1:0] frame_len;

    ds_frame_sequencer_if #(.BITS(BITS)) bus ();

    ds_frame_sequencer #(.BITS(BITS), .DIV_W(DIV_W), .FRAME_W(FRAME_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .div          (div),
        .frame_len    (frame_len),
        .clr_underrun (clr_underrun),
        .bus          (bus.slave),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    logic [BITS-1:0] src_q[$];
    logic [BITS-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // source: offers the head of src_q; the accepted code becomes an expected output
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.s_valid = (src_q.size() > 0);
            bus.s_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    always @(posedge clk)
        if (!rst && bus.s_valid && bus.s_ready && src_q.size() > 0)
            exp_q.push_back(src_q.pop_front());

    logic prev_ready = 1'b1;
    always @(negedge clk) begin
        if (!rst && bus.ds_data_en) begin
            check("en_on_boundary", int'(bus.ds_next && bus.frame_start), 1);
            check("ready_around_pop", int'({prev_ready, bus.s_ready}), 1);
            if (exp_q.size() == 0) check("unexpected_load", 1, 0);
            else                   check("ds_data", int'(bus.ds_data), int'(exp_q.pop_front()));
        end
        prev_ready = bus.s_ready;
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        clr_underrun = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int div; int fl; int ncodes; int c0; int c1;
        int first; int nper; int fper;
    } vec_t;
    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int q, t, t1, t2, last_n, last_f, nb;

        vt[0] = '{3, 0, 1, 'h15, 0,    4, 4, 4};
        vt[1] = '{1, 3, 2, 'h01, 'h02, 2, 2, 8};
        vt[2] = '{0, 2, 1, 'h0A, 0,    1, 1, 3};
        vt[3] = '{2, 1, 0, 0,    0,    3, 3, 6};
        vt[4] = '{0, 0, 1, 'h1F, 0,    1, 1, 1};

        rst = 1'b1; enable = 1'b0; clr_underrun = 1'b0; div = '0; frame_len = '0;
        #3;
        check("rst_s_ready",     int'(bus.s_ready), 1);
        check("rst_ds_next",     int'(bus.ds_next), 0);
        check("rst_ds_data_en",  int'(bus.ds_data_en), 0);
        check("rst_frame_start", int'(bus.frame_start), 0);
        check("rst_ds_data",     int'(bus.ds_data), 0);
        check("rst_underrun",    int'(underrun), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // table: pacing and framing for several div/frame_len combinations
        foreach (vt[i]) begin
            do_reset();
            div = DIV_W'(vt[i].div);
            frame_len = FRAME_W'(vt[i].fl);
            if (vt[i].ncodes >= 1) src_q.push_back(BITS'(vt[i].c0));
            if (vt[i].ncodes >= 2) src_q.push_back(BITS'(vt[i].c1));
            cyc(3);
            check("preload_ready", int'(bus.s_ready), int'(vt[i].ncodes == 0));
            check("idle_quiet", int'(bus.ds_next), 0);
            enable = 1'b1;
            last_n = -1; last_f = -1; nb = 0;
            for (int k = 1; k <= vt[i].first + 3 * vt[i].fper; k++) begin
                cyc(1);
                if (bus.ds_next) begin
                    if (last_n < 0) check("first_next", k, vt[i].first);
                    else            check("next_gap", k - last_n, vt[i].nper);
                    last_n = k;
                end
                if (bus.frame_start) begin
                    nb++;
                    if (last_f < 0) check("first_frame", k, vt[i].first);
                    else            check("frame_gap", k - last_f, vt[i].fper);
                    check("underrun_at_boundary", int'(underrun), int'(nb > vt[i].ncodes));
                    last_f = k;
                end
            end
            check("frames_seen", nb, 4);
            enable = 1'b0;
            cyc(2);
            check("sb_drained", exp_q.size(), 0);
        end

        // async reset mid-run with the buffer full and ds_next high
        do_reset();
        div = '0; frame_len = FRAME_W'(3);
        enable = 1'b1;
        cyc(6);
        src_q.push_back(BITS'('h11));
        for (int k = 0; k < 10 && bus.s_ready; k++) cyc(1);
        check("full_before_rst", int'(bus.s_ready), 0);
        check("next_before_rst", int'(bus.ds_next), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ds_next",     int'(bus.ds_next), 0);
        check("arst_frame_start", int'(bus.frame_start), 0);
        check("arst_s_ready",     int'(bus.s_ready), 1);
        check("arst_underrun",    int'(underrun), 0);
        check("arst_ds_data",     int'(bus.ds_data), 0);
        enable = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        q = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            q += int'(bus.ds_next || bus.ds_data_en || bus.frame_start);
        end
        check("post_rst_quiet", q, 0);
        check("post_rst_ready", int'(bus.s_ready), 1);

        // underrun keeps ds_data; set beats a simultaneous clear
        do_reset();
        div = DIV_W'(1); frame_len = '0;
        src_q.push_back(BITS'('h0C));
        cyc(3);
        enable = 1'b1;
        cyc(6);
        check("underrun_data_kept", int'(bus.ds_data), 'h0C);
        check("underrun_set", int'(underrun), 1);
        cyc(1);
        clr_underrun = 1'b1;
        cyc(1);
        check("clr_vs_set_boundary", int'(bus.ds_next), 1);
        check("clr_vs_set", int'(underrun), 1);
        cyc(1);
        check("clr_alone", int'(underrun), 0);
        clr_underrun = 1'b0;
        cyc(1);
        check("underrun_reset", int'(underrun), 1);
        enable = 1'b0;
        cyc(2);

        // enable drop right before a step: strobe suppressed, buffered code retained
        do_reset();
        div = DIV_W'(2); frame_len = FRAME_W'(2);
        src_q.push_back(BITS'('h05));
        src_q.push_back(BITS'('h16));
        cyc(3);
        enable = 1'b1;
        cyc(3);
        check("drop_first_next", int'(bus.ds_next && bus.frame_start), 1);
        cyc(5);
        check("drop_buffer_full", int'(bus.s_ready), 0);
        enable = 1'b0;
        q = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            q += int'(bus.ds_next || bus.ds_data_en || bus.frame_start);
        end
        check("drop_quiet", q, 0);
        check("drop_retained", int'(bus.s_ready), 0);
        enable = 1'b1;
        cyc(2);
        check("reenable_wait", int'(bus.ds_next), 0);
        cyc(1);
        check("reenable_load", int'(bus.ds_next && bus.ds_data_en && bus.frame_start), 1);
        enable = 1'b0;
        cyc(2);
        check("drop_sb_drained", exp_q.size(), 0);

        // div change mid-period lands only at the next reload
        do_reset();
        div = DIV_W'(3); frame_len = '0;
        enable = 1'b1;
        t = -1;
        for (int k = 1; k <= 10 && t < 0; k++) begin
            cyc(1);
            if (bus.ds_next) t = k;
        end
        check("div_first_seen", int'(t >= 0), 1);
        cyc(1);
        div = DIV_W'(5);
        t1 = -1; t2 = -1;
        for (int k = 2; k <= 20 && t2 < 0; k++) begin
            cyc(1);
            if (bus.ds_next) begin
                if (t1 < 0) t1 = k;
                else        t2 = k;
            end
        end
        check("div_old_period", t1, 4);
        check("div_new_period", t2, 10);
        enable = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
